// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared encodings and types for the memory bus arbiter
// Purpose: bus command encodings (shared with the MSHR), arbiter state and
// tag-owner types, and the memory tag width.
package mem_bus_arbiter_pkg;

  localparam int MEM_TAG_W = 4;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef enum logic [1:0] {
    PRI_D  = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } ARB_STATE_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } ARB_OWNER_t;

endpackage

// File: rtl/mem_tag_table.sv
// rtl/mem_tag_table.sv - 15-entry memory tag ownership table
// Purpose: records which requester owns each outstanding load tag (1..15)
// and routes completions back to that owner.
// Ports:
//   clock, reset          rising-edge clock, async active-low reset
//   wr_en/wr_tag/wr_owner record an accepted load
//   cpl_tag               completion tag from memory (0 = none)
//   cpl_hit_i/cpl_hit_d   completion belongs to Icache / Dcache
//   tag_err               sticky: unknown completion or reuse of a live tag
module mem_tag_table
  import mem_bus_arbiter_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [MEM_TAG_W-1:0] wr_tag,
  input  ARB_OWNER_t           wr_owner,
  input  logic [MEM_TAG_W-1:0] cpl_tag,
  output logic                 cpl_hit_i,
  output logic                 cpl_hit_d,
  output logic                 tag_err
);

  // Entry n describes tag n; tag 0 means "no transaction" and has no entry.
  logic [15:1] valid_q;
  logic [15:1] owner_d_q;

  logic cpl_act;
  logic cpl_valid;
  logic wr_act;
  logic reuse;

  assign cpl_act   = (cpl_tag != '0);
  assign cpl_valid = cpl_act && valid_q[cpl_tag];
  assign wr_act    = wr_en && (wr_tag != '0);

  assign cpl_hit_i = cpl_valid && !owner_d_q[cpl_tag];
  assign cpl_hit_d = cpl_valid &&  owner_d_q[cpl_tag];

  // A tag freed by a completion in the same cycle is legitimately reusable.
  assign reuse = wr_act && valid_q[wr_tag] && !(cpl_valid && (cpl_tag == wr_tag));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q   <= '0;
      owner_d_q <= '0;
      tag_err   <= 1'b0;
    end else begin
      if (cpl_valid) begin
        valid_q[cpl_tag] <= 1'b0;
      end
      // Placed after the clear so a same-tag acceptance wins.
      if (wr_act) begin
        valid_q[wr_tag]   <= 1'b1;
        owner_d_q[wr_tag] <= (wr_owner == OWNER_D);
      end
      if ((cpl_act && !cpl_valid) || reuse) begin
        tag_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - Icache/Dcache arbiter for the single memory port
// Purpose: grants one requester per cycle onto proc2mem_*, returns the
// acceptance tag to the grantee, and routes completions by tag owner.
// Ports:
//   clock, reset                      rising-edge clock, async active-low reset
//   icache_command/addr               fetch unit request
//   dcache_command/addr/data          MSHR head request
//   proc2mem_command/addr/data        memory port request
//   mem2proc_response/data/tag        memory acceptance tag, return data, completion tag
//   icache_response, dcache_response  acceptance tag to the granted requester
//   icache_tag, dcache_tag            completion tag to the owning requester
//   mem_data_out                      return data broadcast
//   tag_err                           sticky tag bookkeeping error
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           icache_command,
  input  logic [63:0]          icache_addr,
  input  logic [1:0]           dcache_command,
  input  logic [63:0]          dcache_addr,
  input  logic [63:0]          dcache_data,
  output logic [1:0]           proc2mem_command,
  output logic [63:0]          proc2mem_addr,
  output logic [63:0]          proc2mem_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_response,
  input  logic [63:0]          mem2proc_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_tag,
  output logic [MEM_TAG_W-1:0] icache_response,
  output logic [MEM_TAG_W-1:0] icache_tag,
  output logic [MEM_TAG_W-1:0] dcache_response,
  output logic [MEM_TAG_W-1:0] dcache_tag,
  output logic [63:0]          mem_data_out,
  output logic                 tag_err
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  ARB_STATE_t       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic i_act, d_act;
  logic grant_i, grant_d;
  logic resp_hit, accept_i, accept_d;
  logic tbl_wr;
  logic hit_i, hit_d;

  assign i_act    = (icache_command != BUS_NONE);
  assign d_act    = (dcache_command != BUS_NONE);
  assign resp_hit = (mem2proc_response != '0);
  assign accept_i = grant_i && resp_hit;
  assign accept_d = grant_d && resp_hit;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    state_d = PRI_D;
    case (state_q)
      // A locked requester that drops its command is simply not granted.
      LOCK_I: grant_i = i_act;
      LOCK_D: grant_d = d_act;
      default: begin
        if (i_act && d_act) begin
          if (starve_q == LIMIT) grant_i = 1'b1;
          else                   grant_d = 1'b1;
        end else begin
          grant_i = i_act;
          grant_d = d_act;
        end
      end
    endcase
    // A stalled grant is held until memory accepts it.
    if (grant_i && !resp_hit)      state_d = LOCK_I;
    else if (grant_d && !resp_hit) state_d = LOCK_D;
  end

  always_comb begin
    starve_d = starve_q;
    if (!i_act || accept_i) begin
      starve_d = '0;
    end else if (accept_d && (starve_q != LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= PRI_D;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign proc2mem_command = grant_i ? icache_command : (grant_d ? dcache_command : BUS_NONE);
  assign proc2mem_addr    = grant_i ? icache_addr    : (grant_d ? dcache_addr    : 64'd0);
  assign proc2mem_data    = grant_d ? dcache_data : 64'd0;

  assign icache_response = grant_i ? mem2proc_response : '0;
  assign dcache_response = grant_d ? mem2proc_response : '0;

  // Stores never complete with data, so only loads get an owner entry.
  assign tbl_wr = (accept_i || accept_d) && (proc2mem_command == BUS_LOAD);

  mem_tag_table u_tag_table (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (tbl_wr),
    .wr_tag    (mem2proc_response),
    .wr_owner  (accept_d ? OWNER_D : OWNER_I),
    .cpl_tag   (mem2proc_tag),
    .cpl_hit_i (hit_i),
    .cpl_hit_d (hit_d),
    .tag_err   (tag_err)
  );

  assign icache_tag   = hit_i ? mem2proc_tag : '0;
  assign dcache_tag   = hit_d ? mem2proc_tag : '0;
  assign mem_data_out = mem2proc_data;

endmodule
